// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: start/done sequencer wrapped around an external 32-bit combinational ALU.
// Single-pass ops take one ALU pass. Shifts repeat the ALU's 1-bit shift once per
// cycle, feeding each result back through the accumulator.

module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        flag_z,
    output logic        flag_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_funct,
    input  logic [31:0] alu_out,
    input  logic        alu_flag_z
);

    localparam logic [3:0] FnSla = 4'b0110;
    localparam logic [3:0] FnSra = 4'b0111;
    localparam logic [3:0] FnSrl = 4'b1000;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q;
    logic [31:0] b_reg_q;
    logic [4:0]  count_q;
    logic [3:0]  f_reg_q;
    logic        sgn_q;
    logic [31:0] result_q;
    logic        flag_z_q;
    logic        flag_s_q;
    logic        done_q;

    logic        accept;
    logic        last_pass;
    logic        new_is_shift;
    logic        cur_is_shift;

    assign new_is_shift = (funct == FnSla) || (funct == FnSra) || (funct == FnSrl);
    assign cur_is_shift = (f_reg_q == FnSla) || (f_reg_q == FnSra) || (f_reg_q == FnSrl);
    assign accept       = (state_q == StIdle) && start;
    // count is 0 only for zero-amount shifts, which still take a single pass
    assign last_pass    = (state_q == StExec) && (count_q <= 5'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StExec;
            StExec: if (count_q <= 5'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: busy flag and ALU drive from the operand registers
    always_comb begin
        busy      = (state_q == StExec);
        alu_a     = acc_q;
        alu_funct = f_reg_q;
        if (cur_is_shift) begin
            alu_b = {31'd0, (count_q != 5'd0)};
        end else begin
            alu_b = b_reg_q;
        end
    end

    // Operand capture on accept and accumulator/counter iteration during EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= 32'd0;
            b_reg_q <= 32'd0;
            count_q <= 5'd0;
            f_reg_q <= 4'd0;
            sgn_q   <= 1'b0;
        end else if (accept) begin
            acc_q   <= op_a;
            b_reg_q <= op_b;
            count_q <= new_is_shift ? op_b[4:0] : 5'd1;
            f_reg_q <= funct;
            sgn_q   <= op_a[31];
        end else if (state_q == StExec) begin
            acc_q   <= alu_out;
            count_q <= (count_q != 5'd0) ? (count_q - 5'd1) : 5'd0;
        end
    end

    // Publish result and flags on the final pass; done pulses the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'd0;
            flag_z_q <= 1'b0;
            flag_s_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_pass;
            if (last_pass) begin
                result_q <= alu_out;
                flag_z_q <= alu_flag_z;
                flag_s_q <= sgn_q;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign flag_z = flag_z_q;
    assign flag_s = flag_s_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the external ALU.

module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_z;
    logic        flag_s;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_funct;
    logic [31:0] alu_out;
    logic        alu_flag_z;

    int errors;
    int checks;
    int lat;
    int busy_cycles;

    alu_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .funct      (funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flag_z     (flag_z),
        .flag_s     (flag_s),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .alu_out    (alu_out),
        .alu_flag_z (alu_flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU model; shifts move by alu_b[4:0]
    always_comb begin
        case (alu_funct)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = ~alu_a;
            4'b0110: alu_out = alu_a << alu_b[4:0];
            4'b0111: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1000: alu_out = alu_a >> alu_b[4:0];
            default: alu_out = 32'd0;
        endcase
        alu_flag_z = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request so that it is sampled on the next rising edge; returns in cycle T+1
    task automatic start_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        funct = f;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat is the cycle offset from the accepting edge
    task automatic wait_done(input string tag);
        lat         = 1;
        busy_cycles = 0;
        while (!done && lat < 64) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_z, input logic exp_s);
        start_op(f, a, b);
        wait_done(tag);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cycles, exp_lat - 1);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flag_z"}, {31'd0, flag_z}, {31'd0, exp_z});
        chk({tag, "_flag_s"}, {31'd0, flag_s}, {31'd0, exp_s});
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        funct  = 4'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, flag_z, flag_s}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add", 4'b0000, 32'd5, 32'd7, 2, 32'd12, 1'b0, 1'b0);
        run_op("sub", 4'b0001, 32'd7, 32'd7, 2, 32'd0, 1'b1, 1'b0);
        run_op("sla31", 4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 32, 32'h8000_0000, 1'b0, 1'b0);
        run_op("sla0", 4'b0110, 32'h0000_0001, 32'h0000_0000, 2, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sra4", 4'b0111, 32'h8000_0000, 32'd4, 5, 32'hF800_0000, 1'b0, 1'b1);
        run_op("srl4", 4'b1000, 32'h8000_0000, 32'd4, 5, 32'h0800_0000, 1'b0, 1'b1);
        run_op("xor", 4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 2, 32'hF00F_F00F, 1'b0, 1'b1);
        run_op("bad", 4'b1111, 32'h0000_1234, 32'h0000_0001, 2, 32'd0, 1'b1, 1'b0);

        // start while busy is ignored; start in the done cycle is accepted
        start_op(4'b1000, 32'h8000_0000, 32'd10);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start_op(4'b0000, 32'd1, 32'd1);
        chk("busy_ign_busy", {31'd0, busy}, 32'd1);
        wait_done("busy_ign");
        chk("busy_ign_latency", lat + 4, 11);
        chk("busy_ign_result", result, 32'h0020_0000);
        chk("busy_ign_flag_s", {31'd0, flag_s}, 32'd1);
        start_op(4'b0000, 32'd1, 32'd1);
        chk("b2b_not_done", {31'd0, done}, 32'd0);
        wait_done("b2b");
        chk("b2b_latency", lat, 2);
        chk("b2b_result", result, 32'd2);
        chk("b2b_flag_s", {31'd0, flag_s}, 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-shift clears published state immediately
        run_op("pre_rst", 4'b0000, 32'h8000_0000, 32'd1, 2, 32'h8000_0001, 1'b0, 1'b1);
        start_op(4'b0110, 32'd3, 32'd20);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_flags", {30'd0, flag_z, flag_s}, 32'd0);
        #10;
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) lat++;
        end
        chk("post_rst_quiet", lat, 0);
        chk("post_rst_result", result, 32'd0);

        run_op("after_rst", 4'b0000, 32'd2, 32'd3, 2, 32'd5, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that owns the combinational 32-bit ALU and turns it into a start/done execution unit. Single-pass operations (ADD, SUB, AND, OR, XOR, NOT) complete in one ALU pass. Shift operations by 0-31 bit positions are built by iterating the ALU's 1-bit shift, feeding each result back. The block sits between the instruction/control logic and the ALU instance, driving the ALU operand and function inputs and registering its outputs.

## Interface
- No parameters. Datapath width is fixed at 32, shift-amount width at 5.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request; sampled only when busy=0
- funct  in  4  ALU op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SLA, 0111 SRA, 1000 SRL, others give result 0
- op_a  in  32  operand A (signed for ADD/SUB/SRA)
- op_b  in  32  operand B; shift ops use op_b[4:0] as the amount, bits 31:5 ignored
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result/flags valid from this cycle
- result  out  32  registered result, held until the next completion
- flag_z  out  1  registered: final ALU pass produced zero
- flag_s  out  1  registered: op_a[31] of the accepted request
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_funct  out  4  to ALU funct
- alu_out  in  32  from ALU out
- alu_flag_z  in  1  from ALU flagZ

## Operation
- FSM states:
  - IDLE: busy=0.
  - EXEC: busy=1.
- IDLE -> EXEC when start=1. On that edge, capture:
  - funct into f_reg
  - op_a into acc
  - op_a[31] into sgn
  - op_b into b_reg
  - count = op_b[4:0] for shift ops, 1 otherwise
- EXEC, ALU drive:
  - alu_a=acc, alu_funct=f_reg.
  - alu_b=b_reg for non-shift ops.
  - For shift ops, alu_b=32'd1 while count!=0, and 32'd0 when count=0 (zero-amount shift).
- EXEC, each cycle:
  - acc <= alu_out
  - count <= count-1, saturating at 0
- Last EXEC cycle is when count<=1 (count=0 only for zero-amount shifts). On it:
  - result <= alu_out
  - flag_z <= alu_flag_z
  - flag_s <= sgn
  - done <= 1
  - state -> IDLE
- Shift semantics per iteration: SLA shifts left by 1, SRA shifts right arithmetic by 1, SRL shifts right logical by 1. Net effect equals op_a shifted by op_b[4:0].
- Undefined funct (1001-1111): one EXEC cycle, result 0, flag_z 1.
- In IDLE, alu_a/alu_b/alu_funct hold their last values. Only the EXEC drive is guaranteed.
- start while busy=1 is ignored; no queuing.
- Reset (rst_n=0), asynchronous and valid at any time including mid-EXEC:
  - state IDLE
  - busy 0, done 0
  - result 0, flag_z 0, flag_s 0
  - acc, b_reg, count, f_reg all 0
  - No partial result is published.

## Timing
- start accepted at edge T: busy=1 in cycle T+1, first ALU pass in cycle T+1.
- Non-shift ops, and shifts with amount 0 or 1: done=1 and result valid in T+2.
- Shift by n (2..31): n EXEC cycles; done=1 in cycle T+1+n. Max latency is 32 cycles (n=31).
- busy drops in the same cycle that done rises.
- done is high for exactly one cycle. It is asserted only in the cycle right after the last EXEC cycle, even if start is high in that cycle.
- start=1 in the done cycle is accepted, giving back-to-back ops. Throughput for single-pass ops is 1 op per 2 cycles.
- result and flags change only on completion or reset.

## Test plan
- Single-pass ADD: op_a=5, op_b=7, funct=0000 -> done at T+2, result=12, flag_z=0, flag_s=0. Then SUB 7-7 -> result=0, flag_z=1.
- SLA by 31: op_a=0x00000001, op_b=0xFFFFFFFF (amount 31), funct=0110 -> busy for 31 cycles, done at T+32, result=0x80000000, flag_s=0. Same op with op_b=0 -> done at T+2, result=0x00000001.
- SRA/SRL by 4: op_a=0x80000000, op_b=4 -> SRA result=0xF8000000, flag_s=1; SRL result=0x08000000, flag_s=1. Both done at T+5.
- Busy/back-to-back: during a 10-step SRL, pulse start with ADD 1+1 -> ignored, SRL result intact. Start ADD 1+1 in the done cycle -> accepted, result=2 two cycles later.
- Invalid funct 1111: op_a=0x1234, op_b=0x1 -> done at T+2, result=0, flag_z=1.
- Reset mid-shift: assert rst_n=0 five cycles into a 20-step SLA -> busy, done, result and flags are 0 immediately without waiting for clk. After release, no done pulse occurs until a new start.
